// File: rtl/axil_to_apb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB3 bridge.
//   state_e       : bridge FSM states
//   arb_e         : which request class was granted last (round-robin memory)
//   RESP_*        : AXI response encodings
//   TIMEOUT_RDATA : read data returned when an APB access is aborted
package axil_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic {
    ARB_READ  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axil_to_apb_bridge_if.sv
// Bus interfaces for the AXI4-Lite to APB3 bridge.
//   axil_if : AXI4-Lite channels AW/W/B/AR/R.
//             master modport = requester, slave modport = bridge.
//   apb_if  : APB3 psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr.
//             master modport = bridge, slave modport = target.
interface axil_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

interface apb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/axil_to_apb_bridge.sv
// AXI4-Lite slave to APB3 master bridge, one transaction in flight.
// Ports:
//   pclk   : single clock for both sides
//   preset : synchronous active-high reset
//   s      : axil_if.slave  - AXI4-Lite requests from the fabric
//   out    : apb_if.master  - APB3 master toward the address-split stage
// Writes need AW and W valid together; partial strobes are refused with
// SLVERR without touching APB. Read/write ties alternate round-robin,
// reads winning the first tie after reset.
// Optional macro AXIL_APB_BRIDGE_TIMEOUT_EN: abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without pready, answering SLVERR (reads return
// 32'hDEAD_BEEF).
module axil_to_apb_bridge
  import axil_apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic   pclk,
  input  logic   preset,
  axil_if.slave  s,
  apb_if.master  out
);

  state_e            state_q, state_d;
  arb_e              rr_last_q;
  logic              is_wr_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pwrite_q;
  logic [1:0]        resp_q;

  logic wr_elig, rd_elig, idle_ok, grant_wr, grant_rd, strb_full;
  logic access_done, timeout_hit;

  assign wr_elig   = s.awvalid & s.wvalid;
  assign rd_elig   = s.arvalid;
  // Readys are gated by reset so every output reads 0 while preset is high.
  assign idle_ok   = (state_q == IDLE) & ~preset;
  assign grant_wr  = idle_ok & wr_elig & (~rd_elig | (rr_last_q == ARB_READ));
  assign grant_rd  = idle_ok & rd_elig & ~grant_wr;
  assign strb_full = &s.wstrb;

  assign access_done = (state_q == ACCESS) & out.pready;

`ifdef AXIL_APB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge pclk) begin
    if (preset || state_q == SETUP) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !out.pready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // pready on the final counted cycle still completes normally.
  assign timeout_hit = (state_q == ACCESS) & ~out.pready & (cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_wr && !strb_full) begin
          state_d = RESP;
        end else if (grant_wr || grant_rd) begin
          state_d = SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (out.pready || timeout_hit) state_d = RESP;
      RESP: begin
        if ((is_wr_q && s.bready) || (!is_wr_q && s.rready)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out.psel    = (state_q == SETUP) || (state_q == ACCESS);
    out.penable = (state_q == ACCESS);
    s.bvalid    = (state_q == RESP) && is_wr_q;
    s.rvalid    = (state_q == RESP) && !is_wr_q;
    s.awready   = grant_wr;
    s.wready    = grant_wr;
    s.arready   = grant_rd;
  end

  assign out.pwrite = pwrite_q;
  assign out.paddr  = paddr_q;
  assign out.pwdata = pwdata_q;
  assign s.bresp    = resp_q;
  assign s.rresp    = resp_q;
  assign s.rdata    = rdata_q;

  // Request capture and response datapath
  always_ff @(posedge pclk) begin
    if (preset) begin
      rr_last_q <= ARB_WRITE;
      is_wr_q   <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      if (grant_wr) begin
        rr_last_q <= ARB_WRITE;
        is_wr_q   <= 1'b1;
        if (strb_full) begin
          paddr_q  <= {s.awaddr[ADDR_W-1:2], 2'b00};
          pwdata_q <= s.wdata;
          pwrite_q <= 1'b1;
        end else begin
          // Refused write: APB-side registers keep the last transfer's values.
          resp_q <= RESP_SLVERR;
        end
      end
      if (grant_rd) begin
        rr_last_q <= ARB_READ;
        is_wr_q   <= 1'b0;
        paddr_q   <= {s.araddr[ADDR_W-1:2], 2'b00};
        pwrite_q  <= 1'b0;
      end
      if (access_done) begin
        resp_q <= out.pslverr ? RESP_SLVERR : RESP_OKAY;
        if (!is_wr_q) rdata_q <= out.prdata;
      end else if (timeout_hit) begin
        resp_q <= RESP_SLVERR;
        if (!is_wr_q) rdata_q <= TIMEOUT_RDATA;
      end
    end
  end

endmodule
